// File: rtl/systolic_output_collector.sv
// Collects N consecutive bottom-edge psum rows from the systolic array after a
// programmable fill latency, then drains them row by row over a valid/ready port.
module systolic_output_collector #(
    parameter int N      = 4,
    parameter int PSUM_W = 24,
    parameter int LAT_W  = 8,
    localparam int ROW_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [LAT_W-1:0]    cfg_latency,
    input  logic [N*PSUM_W-1:0] pe_output,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N*PSUM_W-1:0] out_data,
    output logic [ROW_W-1:0]    out_row,
    output logic                out_last,
    output logic                busy,
    output logic                done,
    output logic [1:0]          state_dbg
);

    // Handshake: a row transfers on a cycle where out_valid && out_ready. While
    // out_valid is high and out_ready low, out_data/out_row/out_last hold steady,
    // and out_valid only falls after the last row's transfer (or on reset).

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_CAPTURE = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N - 1);

    state_t              state_q, state_d;
    logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
    logic [ROW_W-1:0]    row_cnt_q, row_cnt_d;
    logic [N*PSUM_W-1:0] row_buf_q [N];
    logic [N*PSUM_W-1:0] row_buf_d [N];
    logic                row_is_last;

    assign row_is_last = (row_cnt_q == LAST_ROW);
    assign state_dbg   = state_q;

    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        row_cnt_d = row_cnt_q;
        row_buf_d = row_buf_q;
        out_valid = 1'b0;
        out_data  = '0;
        out_row   = '0;
        out_last  = 1'b0;
        done      = 1'b0;
        busy      = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    row_cnt_d = '0;
                    // lat_cnt holds the WAIT cycles still to spend; latencies 0 and 1
                    // both capture in the cycle right after start.
                    if (cfg_latency > LAT_W'(1)) begin
                        lat_cnt_d = cfg_latency - LAT_W'(1);
                        state_d   = S_WAIT;
                    end else begin
                        lat_cnt_d = '0;
                        state_d   = S_CAPTURE;
                    end
                end
            end
            S_WAIT: begin
                lat_cnt_d = lat_cnt_q - LAT_W'(1);
                if (lat_cnt_q == LAT_W'(1)) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                row_buf_d[row_cnt_q] = pe_output;
                if (row_is_last) begin
                    row_cnt_d = '0;
                    state_d   = S_DRAIN;
                end else begin
                    row_cnt_d = row_cnt_q + ROW_W'(1);
                end
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                out_data  = row_buf_q[row_cnt_q];
                out_row   = row_cnt_q;
                out_last  = row_is_last;
                if (out_ready) begin
                    if (row_is_last) begin
                        done      = 1'b1;
                        row_cnt_d = '0;
                        state_d   = S_IDLE;
                    end else begin
                        row_cnt_d = row_cnt_q + ROW_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            lat_cnt_q <= '0;
            row_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            row_cnt_q <= row_cnt_d;
        end
    end

    // Buffer contents are only read after a full capture, so they carry no reset.
    always_ff @(posedge clk) begin
        row_buf_q <= row_buf_d;
    end

endmodule

// File: tb/tb_systolic_output_collector.sv
// Directed job sequence with randomized data, latency and back-pressure, checked
// against a cycle-indexed job model (expected row queue) kept in the bench.
module tb_systolic_output_collector;

    localparam int N      = 4;
    localparam int PSUM_W = 24;
    localparam int LAT_W  = 8;
    localparam int ROW_W  = 2;
    localparam int DW     = N * PSUM_W;

    logic              clk;
    logic              rst;
    logic              start;
    logic [LAT_W-1:0]  cfg_latency;
    logic [DW-1:0]     pe_output;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [ROW_W-1:0]  out_row;
    logic              out_last;
    logic              busy;
    logic              done;
    logic [1:0]        state_dbg;

    int n_tests;
    int n_fail;

    systolic_output_collector #(
        .N      (N),
        .PSUM_W (PSUM_W),
        .LAT_W  (LAT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cfg_latency (cfg_latency),
        .pe_output   (pe_output),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_row     (out_row),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done),
        .state_dbg   (state_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] junk_row();
        logic [DW-1:0] v;
        for (int k = 0; k < N; k++) v[k*PSUM_W +: PSUM_W] = PSUM_W'($urandom);
        return v;
    endfunction

    // data_mode 0: random, 1: row*16+lane, 2: lanes alternate FFFFFF / 800000
    function automatic logic [DW-1:0] job_row(input int data_mode, input int r);
        logic [DW-1:0] v;
        v = junk_row();
        if (data_mode == 1) begin
            for (int k = 0; k < N; k++) v[k*PSUM_W +: PSUM_W] = PSUM_W'(r * 16 + k);
        end else if (data_mode == 2) begin
            for (int k = 0; k < N; k++)
                v[k*PSUM_W +: PSUM_W] = (((k + r) % 2) == 0) ? 24'hFFFFFF : 24'h800000;
        end
        return v;
    endfunction

    // The model: with start in cycle 0, rows are sampled in cycles c0..c0+N-1,
    // where c0 = max(latency,1); rows then leave in order, one per accepted transfer.
    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 128'(out_valid), 128'(0));
        check({tag, "_busy"},  128'(busy),      128'(0));
        check({tag, "_done"},  128'(done),      128'(0));
        check({tag, "_row"},   128'(out_row),   128'(0));
        check({tag, "_data"},  128'(out_data),  128'(0));
    endtask

    task automatic run_job(input int lat, input int data_mode, input int rdy_mode,
                           input bit extra_starts, input int abort_at);
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] row_v;
        int c0;
        int drained;
        int k;
        logic rdy;
        bit rdy_pat [7];
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        c0 = (lat <= 1) ? 1 : lat;

        start       = 1'b1;
        cfg_latency = LAT_W'(lat);
        pe_output   = junk_row();
        out_ready   = 1'($urandom);
        #1;
        check("start_busy",  128'(busy),      128'(0));
        check("start_valid", 128'(out_valid), 128'(0));
        tick();

        for (int t = 1; t < c0 + N; t++) begin
            start       = extra_starts;
            cfg_latency = LAT_W'($urandom);
            out_ready   = 1'($urandom);
            if (t >= c0) begin
                row_v = job_row(data_mode, t - c0);
                exp_q.push_back(row_v);
                pe_output = row_v;
            end else begin
                pe_output = junk_row();
            end
            #1;
            check("fill_busy",  128'(busy),      128'(1));
            check("fill_valid", 128'(out_valid), 128'(0));
            check("fill_done",  128'(done),      128'(0));
            tick();
        end

        drained = 0;
        k = 0;
        while (drained < N && k < 64) begin
            if (rdy_mode == 0) rdy = 1'b1;
            else if (rdy_mode == 1) rdy = (k < 7) ? rdy_pat[k] : 1'b1;
            else rdy = 1'($urandom);
            if (abort_at == drained) rdy = 1'b0;
            out_ready = rdy;
            start     = extra_starts;
            pe_output = junk_row();
            #1;
            check("drain_valid", 128'(out_valid), 128'(1));
            check("drain_busy",  128'(busy),      128'(1));
            check("drain_data",  128'(out_data),  128'(exp_q[0]));
            check("drain_row",   128'(out_row),   128'(drained));
            check("drain_last",  128'(out_last),  128'(drained == N - 1));
            check("drain_done",  128'(done),      128'(rdy && drained == N - 1));
            if (abort_at == drained) begin
                rst = 1'b1;
                tick();
                rst   = 1'b0;
                start = 1'b0;
                #1;
                check_idle("abort");
                return;
            end
            if (rdy) begin
                void'(exp_q.pop_front());
                drained++;
            end
            tick();
            k++;
        end
        check("drain_count", 128'(drained), 128'(N));
        start = 1'b0;
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst         = 1'b1;
        start       = 1'b0;
        cfg_latency = '0;
        pe_output   = '0;
        out_ready   = 1'b0;
        tick();
        tick();
        check_idle("reset");
        rst = 1'b0;
        tick();
        check_idle("post_reset");

        // T1: latency 3, ramp data, always ready
        run_job(3, 1, 0, 1'b0, -1);
        check_idle("t1_end");
        // T2: zero latency
        run_job(0, 0, 0, 1'b0, -1);
        check_idle("t2_end");
        // latency 1 and 2 edge cases
        run_job(1, 0, 0, 1'b0, -1);
        run_job(2, 0, 2, 1'b0, -1);
        tick();
        // T3: fixed back-pressure pattern
        run_job(3, 0, 1, 1'b0, -1);
        check_idle("t3_end");
        // T4: start held high through the whole job, including the done cycle
        run_job(3, 1, 0, 1'b1, -1);
        check_idle("t4_end");
        // T5: reset while row 1 is presented, then a clean job
        run_job(4, 0, 0, 1'b0, 1);
        tick();
        check_idle("t5_after");
        run_job(3, 1, 0, 1'b0, -1);
        // T6: extreme lane values, then back-to-back jobs
        run_job(2, 2, 0, 1'b0, -1);
        run_job(5, 2, 2, 1'b0, -1);
        run_job(0, 0, 0, 1'b0, -1);
        check_idle("t6_end");
        // randomized jobs
        for (int j = 0; j < 8; j++) begin
            run_job(int'($urandom_range(0, 9)), 0, 2, 1'($urandom), -1);
            if ($urandom_range(0, 1) == 1) tick();
        end
        tick();
        check_idle("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
